// File: rtl/cfg_load_if.sv
// Bus between the configuration-load controller and its byte source, shift register and ADC.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready; adc_ready is a completion strobe sampled only while adc_start is high.
interface cfg_load_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       load_go;
    logic       auto_conv;
    logic       shift_en;
    logic       shift_data;
    logic       adc_start;
    logic       adc_ready;
    logic [7:0] adc_data;
    logic [7:0] result;
    logic       result_valid;
    logic       timeout;
    logic       busy;

    modport slave (
        input  byte_in, byte_valid, load_go, auto_conv, adc_ready, adc_data,
        output byte_ready, shift_en, shift_data, adc_start, result, result_valid, timeout, busy
    );

    modport master (
        output byte_in, byte_valid, load_go, auto_conv, adc_ready, adc_data,
        input  byte_ready, shift_en, shift_data, adc_start, result, result_valid, timeout, busy
    );
endinterface

// File: rtl/cfg_load_ctrl.sv
// Collects NBYTES configuration bytes, shifts the low WIDTH bits out MSB first, then optionally waits for one ADC conversion.
// dbg_state_o encoding: 0 FILL, 1 ARMED, 2 SHIFT, 3 CONV.
module cfg_load_ctrl #(
    parameter int WIDTH   = 79,
    parameter int NBYTES  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    cfg_load_if.slave  bus,
    output logic [1:0] dbg_state_o
);
    localparam int BUFW = NBYTES * 8;
    localparam int BCW  = $clog2(NBYTES + 1);
    localparam int BIW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SCW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int WCW  = $clog2(TIMEOUT + 1);
    localparam int XIW  = (BUFW > 1) ? $clog2(BUFW) : 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        CONV  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [BCW-1:0]            byte_cnt_q, byte_cnt_d;
    logic [SCW-1:0]            shift_cnt_q, shift_cnt_d;
    logic [WCW-1:0]            wait_cnt_q, wait_cnt_d;
    logic [NBYTES-1:0][7:0]    buf_q, buf_d;
    logic                      auto_q, auto_d;
    logic [7:0]                result_q, result_d;
    logic                      result_valid_q, result_valid_d;
    logic                      timeout_q, timeout_d;

    logic [BIW-1:0]            byte_idx;
    logic [XIW-1:0]            shift_idx;
    logic [BUFW-1:0]           buf_flat;
    logic                      byte_last, shift_last, conv_expired;

    assign byte_idx     = BIW'(byte_cnt_q);
    assign shift_idx    = XIW'(WIDTH - 1) - XIW'(shift_cnt_q);
    assign buf_flat     = buf_q;
    assign byte_last    = (byte_cnt_q == BCW'(NBYTES - 1));
    assign shift_last   = (shift_cnt_q == SCW'(WIDTH - 1));
    assign conv_expired = (wait_cnt_q == WCW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q     <= '0;
            shift_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            buf_q          <= '0;
            auto_q         <= 1'b0;
            result_q       <= 8'h00;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            byte_cnt_q     <= byte_cnt_d;
            shift_cnt_q    <= shift_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            buf_q          <= buf_d;
            auto_q         <= auto_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (bus.byte_valid && byte_last) state_d = ARMED;
            ARMED:   if (bus.load_go) state_d = SHIFT;
            SHIFT:   if (shift_last) state_d = auto_q ? CONV : FILL;
            CONV:    if (bus.adc_ready || conv_expired) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Result/timeout pulses default low so each lasts exactly the cycle after the deciding edge.
    always_comb begin
        byte_cnt_d     = byte_cnt_q;
        shift_cnt_d    = shift_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        buf_d          = buf_q;
        auto_d         = auto_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_d      = 1'b0;
        case (state_q)
            FILL: begin
                if (bus.byte_valid) begin
                    buf_d[byte_idx] = bus.byte_in;
                    byte_cnt_d      = byte_cnt_q + 1'b1;
                end
            end
            ARMED: begin
                if (bus.load_go) begin
                    auto_d      = bus.auto_conv;
                    shift_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    byte_cnt_d = '0;
                    wait_cnt_d = '0;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            CONV: begin
                if (bus.adc_ready) begin
                    result_d       = bus.adc_data;
                    result_valid_d = 1'b1;
                    byte_cnt_d     = '0;
                end else if (conv_expired) begin
                    timeout_d  = 1'b1;
                    byte_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.byte_ready   = (state_q == FILL);
        bus.shift_en     = (state_q == SHIFT);
        bus.shift_data   = (state_q == SHIFT) ? buf_flat[shift_idx] : 1'b0;
        bus.adc_start    = (state_q == CONV);
        bus.busy         = (state_q == SHIFT) || (state_q == CONV);
        bus.result       = result_q;
        bus.result_valid = result_valid_q;
        bus.timeout      = timeout_q;
        dbg_state_o      = state_q;
    end
endmodule

// File: tb/tb_cfg_load_ctrl.sv
// Directed bench for cfg_load_ctrl: drivers push the per-cycle expected outputs, one compare process checks them.
module tb_cfg_load_ctrl;
    localparam int WIDTH   = 79;
    localparam int NBYTES  = 10;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cfg_load_if bus_if ();
    logic [1:0] dbg_state;

    cfg_load_ctrl #(.WIDTH(WIDTH), .NBYTES(NBYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // Expected word per cycle: {byte_ready, shift_en, shift_data, adc_start, busy, result_valid, timeout, result[7:0]}
    logic [14:0] exp_q[$];
    logic [NBYTES*8-1:0] model_buf;
    logic [7:0] model_result;
    logic [NBYTES*8-1:0] lit;
    logic [WIDTH-1:0] dn_reg;
    int shift_seen, adc_seen, rv_seen, to_seen;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] flags();
        return {bus_if.byte_ready, bus_if.shift_en, bus_if.shift_data, bus_if.adc_start,
                bus_if.busy, bus_if.result_valid, bus_if.timeout};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic br, input logic se, input logic sd, input logic as,
                              input logic bz, input logic rv, input logic to);
        exp_q.push_back({br, se, sd, as, bz, rv, to, model_result});
    endtask

    // Compare process and downstream shift-register model
    always @(negedge clk) begin
        logic [14:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_flags", 80'(flags()), 80'(e[14:8]));
            chk("cycle_result", 80'(bus_if.result), 80'(e[7:0]));
        end
        if (bus_if.shift_en) begin
            shift_seen++;
            dn_reg = {dn_reg[WIDTH-2:0], bus_if.shift_data};
        end
        if (bus_if.adc_start) adc_seen++;
        if (bus_if.result_valid) rv_seen++;
        if (bus_if.timeout) to_seen++;
    end

    task automatic fill(input logic [7:0] base, input logic [7:0] step, input bit gaps);
        logic [7:0] v;
        for (int i = 0; i < NBYTES; i++) begin
            if (gaps && (i % 3 == 1)) begin
                bus_if.byte_valid = 1'b0;
                bus_if.byte_in    = 8'hEE;
                bus_if.load_go    = 1'b1;
                cyc();
                expect_out(1, 0, 0, 0, 0, 0, 0);
                bus_if.load_go = 1'b0;
            end
            v = base + 8'(i) * step;
            bus_if.byte_valid = 1'b1;
            bus_if.byte_in    = v;
            cyc();
            model_buf[8*i +: 8] = v;
            expect_out(i != NBYTES - 1, 0, 0, 0, 0, 0, 0);
        end
        bus_if.byte_valid = 1'b0;
        chk("state_armed", 80'(dbg_state), 80'(2'd1));
    endtask

    task automatic do_abort(input int at);
        #1;
        chk("pre_abort_shift_en", 80'(bus_if.shift_en), 80'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("abort_flags", 80'(flags()), 80'(7'b1000000));
        chk("abort_result", 80'(bus_if.result), 80'(8'h00));
        chk("abort_state", 80'(dbg_state), 80'(2'd0));
        model_buf    = '0;
        model_result = 8'h00;
        cyc();
        expect_out(1, 0, 0, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;
        expect_out(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_out(1, 0, 0, 0, 0, 0, 0);
        end
        cyc();
        chk("abort_shift_cycles", 80'(shift_seen), 80'(at));
        chk("abort_no_adc", 80'(adc_seen), 80'(0));
        chk("abort_no_pulses", 80'(rv_seen + to_seen), 80'(0));
    endtask

    // rdy_at: CONV cycle index (0-based) carrying adc_ready, negative for none; abort_at: shift cycle to reset in, negative for none
    task automatic load(input bit auto, input int rdy_at, input logic [7:0] aval, input int abort_at);
        int exp_adc;
        shift_seen = 0; adc_seen = 0; rv_seen = 0; to_seen = 0;
        bus_if.byte_valid = 1'b1;
        bus_if.byte_in    = 8'h77;
        bus_if.adc_ready  = 1'b1;
        cyc();
        expect_out(0, 0, 0, 0, 0, 0, 0);
        bus_if.byte_valid = 1'b0;
        bus_if.load_go    = 1'b1;
        bus_if.auto_conv  = auto;
        cyc();
        bus_if.load_go   = 1'b0;
        bus_if.auto_conv = !auto;
        for (int j = 0; j < WIDTH; j++) begin
            if (j == abort_at) begin
                bus_if.adc_ready = 1'b0;
                do_abort(abort_at);
                return;
            end
            expect_out(0, 1, model_buf[WIDTH-1-j], 0, 1, 0, 0);
            if (j < WIDTH - 1) cyc();
        end
        bus_if.adc_ready = 1'b0;
        cyc();
        if (auto) begin
            for (int w = 0; w < TIMEOUT; w++) begin
                expect_out(0, 0, 0, 1, 1, 0, 0);
                bus_if.adc_ready = (w == rdy_at);
                bus_if.adc_data  = (w == rdy_at) ? aval : 8'h11;
                cyc();
                bus_if.adc_ready = 1'b0;
                if (w == rdy_at) begin
                    model_result = aval;
                    expect_out(1, 0, 0, 0, 0, 1, 0);
                    break;
                end
                if (w == TIMEOUT - 1) expect_out(1, 0, 0, 0, 0, 0, 1);
            end
        end else begin
            expect_out(1, 0, 0, 0, 0, 0, 0);
        end
        cyc();
        expect_out(1, 0, 0, 0, 0, 0, 0);
        cyc();
        exp_adc = auto ? ((rdy_at >= 0) ? rdy_at + 1 : TIMEOUT) : 0;
        chk("shift_en_cycles", 80'(shift_seen), 80'(WIDTH));
        chk("stream_vs_model", 80'(dn_reg), 80'(model_buf[WIDTH-1:0]));
        chk("adc_start_cycles", 80'(adc_seen), 80'(exp_adc));
        chk("result_valid_pulses", 80'(rv_seen), 80'(auto && rdy_at >= 0));
        chk("timeout_pulses", 80'(to_seen), 80'(auto && rdy_at < 0));
        chk("state_fill", 80'(dbg_state), 80'(2'd0));
    endtask

    initial begin
        bus_if.byte_in    = 8'h00;
        bus_if.byte_valid = 1'b0;
        bus_if.load_go    = 1'b0;
        bus_if.auto_conv  = 1'b0;
        bus_if.adc_ready  = 1'b0;
        bus_if.adc_data   = 8'h00;
        model_buf    = '0;
        model_result = 8'h00;
        dn_reg       = '0;
        lit          = 80'h0A090807060504030201;

        #1;
        chk("reset_flags", 80'(flags()), 80'(7'b1000000));
        chk("reset_result", 80'(bus_if.result), 80'(8'h00));
        chk("reset_state", 80'(dbg_state), 80'(2'd0));
        cyc();
        cyc();
        rst_n = 1'b1;
        expect_out(1, 0, 0, 0, 0, 0, 0);

        fill(8'h01, 8'h01, 1'b0);
        chk("model_buf_literal", 80'(model_buf), lit);
        load(1'b0, -1, 8'h00, -1);
        chk("stream_literal", 80'(dn_reg), 80'(lit[WIDTH-1:0]));

        fill(8'h5A, 8'h11, 1'b1);
        load(1'b1, 4, 8'hA5, -1);
        chk("result_a5", 80'(bus_if.result), 80'(8'hA5));

        fill(8'hC3, 8'h07, 1'b0);
        load(1'b1, -1, 8'h00, -1);
        chk("timeout_keeps_result", 80'(bus_if.result), 80'(8'hA5));

        fill(8'h80, 8'h13, 1'b1);
        load(1'b1, TIMEOUT - 1, 8'h5C, -1);
        chk("edge_ready_result", 80'(bus_if.result), 80'(8'h5C));

        fill(8'h33, 8'h05, 1'b0);
        load(1'b0, -1, 8'h00, 40);

        fill(8'hFF, 8'h00, 1'b0);
        load(1'b0, -1, 8'h00, -1);
        chk("all_ones_stream", 80'(dn_reg), 80'({WIDTH{1'b1}}));

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
